// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with inhibit request, ACK check and frame watchdog.
// Define PS2_TX_RETRY_EN to re-send a failed frame up to MAX_RETRIES times before flagging TX_ERROR.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 200,
    parameter int TIMEOUT_US  = 15_000,
    parameter int SYNC_STAGES = 3,
    parameter int MAX_RETRIES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    output logic       CLK_MOUSE_OUT_EN,
    input  logic       DATA_MOUSE_IN,
    output logic       DATA_MOUSE_OUT,
    output logic       DATA_MOUSE_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       TX_ERROR,
    output logic [1:0] ERR_CODE
);
    localparam int CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int INHIBIT_CYC = (CYC_PER_US * INHIBIT_US < 1) ? 1 : CYC_PER_US * INHIBIT_US;
    localparam int TIMEOUT_CYC = (CYC_PER_US * TIMEOUT_US < 1) ? 1 : CYC_PER_US * TIMEOUT_US;
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retry_cnt;
`endif

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t state;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic clk_prev, clk_s, data_s, fall;
    logic [7:0] byte_q, shreg;
    logic parity;
    logic [2:0] bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] wd_cnt;
    logic in_frame, timeout, nack;

    // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a phantom fall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], CLK_MOUSE_IN};
            data_sync <= {data_sync[SYNC_STAGES-2:0], DATA_MOUSE_IN};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_s;
    assign in_frame = state inside {REQ, DATA, PARITY, STOP, WAIT_IDLE};
    assign timeout  = in_frame && wd_cnt == TW'(TIMEOUT_CYC - 1);
    assign nack     = state == STOP && fall && data_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state             <= IDLE;
            byte_q            <= '0;
            shreg             <= '0;
            parity            <= 1'b0;
            bit_cnt           <= '0;
            inh_cnt           <= '0;
            wd_cnt            <= '0;
            CLK_MOUSE_OUT_EN  <= 1'b0;
            DATA_MOUSE_OUT    <= 1'b1;
            DATA_MOUSE_OUT_EN <= 1'b0;
            BUSY              <= 1'b0;
            BYTE_SENT         <= 1'b0;
            TX_ERROR          <= 1'b0;
            ERR_CODE          <= 2'b00;
`ifdef PS2_TX_RETRY_EN
            retry_cnt         <= '0;
`endif
        end else begin
            BYTE_SENT <= 1'b0;
            TX_ERROR  <= 1'b0;
            wd_cnt    <= (in_frame && wd_cnt != TW'(TIMEOUT_CYC - 1)) ? wd_cnt + 1'b1 : wd_cnt;
            // Timeout is checked ahead of the state case so it beats a coincident clock fall.
            if (timeout || nack) begin
                ERR_CODE          <= timeout ? 2'b01 : 2'b10;
                CLK_MOUSE_OUT_EN  <= 1'b0;
                DATA_MOUSE_OUT_EN <= 1'b0;
                DATA_MOUSE_OUT    <= 1'b1;
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt < RW'(MAX_RETRIES)) begin
                    retry_cnt        <= retry_cnt + 1'b1;
                    CLK_MOUSE_OUT_EN <= 1'b1;
                    inh_cnt          <= '0;
                    state            <= INHIBIT;
                end else begin
                    TX_ERROR <= 1'b1;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
`else
                TX_ERROR <= 1'b1;
                BUSY     <= 1'b0;
                state    <= IDLE;
`endif
            end else begin
                case (state)
                    IDLE: if (SEND_BYTE) begin
                        byte_q           <= BYTE_TO_SEND;
                        parity           <= ~^BYTE_TO_SEND;
                        ERR_CODE         <= 2'b00;
                        BUSY             <= 1'b1;
                        CLK_MOUSE_OUT_EN <= 1'b1;
                        inh_cnt          <= '0;
`ifdef PS2_TX_RETRY_EN
                        retry_cnt        <= '0;
`endif
                        state            <= INHIBIT;
                    end
                    INHIBIT: if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
                        CLK_MOUSE_OUT_EN  <= 1'b0;
                        DATA_MOUSE_OUT_EN <= 1'b1;
                        DATA_MOUSE_OUT    <= 1'b0;
                        wd_cnt            <= '0;
                        state             <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                    REQ: if (fall) begin
                        DATA_MOUSE_OUT <= byte_q[0];
                        shreg          <= {1'b0, byte_q[7:1]};
                        bit_cnt        <= '0;
                        state          <= DATA;
                    end
                    DATA: if (fall) begin
                        DATA_MOUSE_OUT <= (bit_cnt == 3'd7) ? parity : shreg[0];
                        shreg          <= {1'b0, shreg[7:1]};
                        bit_cnt        <= bit_cnt + 1'b1;
                        state          <= (bit_cnt == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: if (fall) begin
                        DATA_MOUSE_OUT_EN <= 1'b0;
                        DATA_MOUSE_OUT    <= 1'b1;
                        state             <= STOP;
                    end
                    STOP: if (fall) state <= WAIT_IDLE;
                    WAIT_IDLE: if (clk_s && data_s) begin
                        BYTE_SENT <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed checks of ps2_host_tx against a wired-AND PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int HALF = 20;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic SEND_BYTE = 1'b0;
    logic [7:0] BYTE_TO_SEND = 8'h00;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic CLK_MOUSE_IN, DATA_MOUSE_IN, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN;
    logic BUSY, BYTE_SENT, TX_ERROR;
    logic [1:0] ERR_CODE;
    logic [10:0] cap;
    int compared = 0;
    int mismatched = 0;
    int sent_cnt = 0;
    int err_cnt = 0;
    int inh_seen = 0;
    int run = 0;
    int last_run = 0;

    assign CLK_MOUSE_IN  = dev_clk & ~CLK_MOUSE_OUT_EN;
    assign DATA_MOUSE_IN = dev_data & ~(DATA_MOUSE_OUT_EN & ~DATA_MOUSE_OUT);

    always #5 CLK = ~CLK;

    ps2_host_tx #(.CLK_FREQ_HZ(1_000_000), .INHIBIT_US(10), .TIMEOUT_US(2000)) dut (
        .CLK(CLK), .RESET(RESET),
        .CLK_MOUSE_IN(CLK_MOUSE_IN), .CLK_MOUSE_OUT_EN(CLK_MOUSE_OUT_EN),
        .DATA_MOUSE_IN(DATA_MOUSE_IN), .DATA_MOUSE_OUT(DATA_MOUSE_OUT),
        .DATA_MOUSE_OUT_EN(DATA_MOUSE_OUT_EN),
        .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
        .BUSY(BUSY), .BYTE_SENT(BYTE_SENT), .TX_ERROR(TX_ERROR), .ERR_CODE(ERR_CODE)
    );

    always @(negedge CLK) begin
        if (BYTE_SENT) sent_cnt++;
        if (TX_ERROR) err_cnt++;
        if (CLK_MOUSE_OUT_EN) begin
            if (run == 0) inh_seen++;
            run++;
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        SEND_BYTE = 1'b1;
        BYTE_TO_SEND = b;
        @(negedge CLK);
        SEND_BYTE = 1'b0;
    endtask

    task automatic wait_release();
        int n = 0;
        while (!(BUSY && !CLK_MOUSE_OUT_EN && DATA_MOUSE_OUT_EN) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("release", {31'b0, n < 200}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("idle", {31'b0, BUSY}, 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    // Device side: samples start before the first fall, then one bit per rising edge; drives ACK on fall 11.
    task automatic dev_frame(input logic ack, input int nclk);
        wait_release();
        cap = '1;
        repeat (5) @(negedge CLK);
        cap[0] = DATA_MOUSE_IN;
        for (int i = 1; i <= nclk; i++) begin
            if (i == 11) begin
                dev_data = ack;
                repeat (HALF / 2) @(negedge CLK);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge CLK);
            dev_clk = 1'b1;
            if (i <= 10) cap[i] = DATA_MOUSE_IN;
            repeat (HALF) @(negedge CLK);
        end
        dev_data = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0, e0, i0, n;
        repeat (3) @(negedge CLK);
        check("rst_clk_en", {31'b0, CLK_MOUSE_OUT_EN}, 32'd0);
        check("rst_data_en", {31'b0, DATA_MOUSE_OUT_EN}, 32'd0);
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_sent", {31'b0, BYTE_SENT}, 32'd0);
        check("rst_err", {31'b0, TX_ERROR}, 32'd0);
        check("rst_code", {30'b0, ERR_CODE}, 32'd0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        check("idle_busy", {31'b0, BUSY}, 32'd0);

        s0 = sent_cnt; e0 = err_cnt;
        send(8'hF4);
        check("f4_busy", {31'b0, BUSY}, 32'd1);
        dev_frame(1'b0, 11);
        wait_idle();
        check("f4_frame", {21'b0, cap}, 32'h5E8);
        check("f4_sent", sent_cnt - s0, 32'd1);
        check("f4_err", err_cnt - e0, 32'd0);
        check("f4_code", {30'b0, ERR_CODE}, 32'd0);

        send(8'h00);
        dev_frame(1'b0, 11);
        wait_idle();
        check("z_frame", {21'b0, cap}, 32'h600);
        check("inhibit_len", last_run, 32'd10);

`ifndef PS2_TX_RETRY_EN
        s0 = sent_cnt; e0 = err_cnt;
        send(8'hA5);
        dev_frame(1'b1, 11);
        wait_idle();
        check("nack_err", err_cnt - e0, 32'd1);
        check("nack_sent", sent_cnt - s0, 32'd0);
        check("nack_code", {30'b0, ERR_CODE}, 32'd2);
        check("nack_clk_en", {31'b0, CLK_MOUSE_OUT_EN}, 32'd0);
        check("nack_data_en", {31'b0, DATA_MOUSE_OUT_EN}, 32'd0);

        send(8'h12);
        wait_release();
        n = 0;
        while (!TX_ERROR && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("timeout_cycles", n, 32'd2000);
        check("timeout_code", {30'b0, ERR_CODE}, 32'd1);
        check("timeout_clk_en", {31'b0, CLK_MOUSE_OUT_EN}, 32'd0);
        check("timeout_data_en", {31'b0, DATA_MOUSE_OUT_EN}, 32'd0);
        wait_idle();
`endif

        s0 = sent_cnt;
        send(8'hF4);
        fork
            dev_frame(1'b0, 11);
            begin
                repeat (150) @(negedge CLK);
                SEND_BYTE = 1'b1;
                BYTE_TO_SEND = 8'hFF;
                @(negedge CLK);
                SEND_BYTE = 1'b0;
            end
        join
        wait_idle();
        check("ign_frame", {21'b0, cap}, 32'h5E8);
        check("ign_sent", sent_cnt - s0, 32'd1);
        check("ign_code", {30'b0, ERR_CODE}, 32'd0);
        repeat (30) @(negedge CLK);
        check("ign_busy", {31'b0, BUSY}, 32'd0);

        s0 = sent_cnt; e0 = err_cnt;
        send(8'h3C);
        dev_frame(1'b0, 3);
        check("pre_rst_data_en", {31'b0, DATA_MOUSE_OUT_EN}, 32'd1);
        #1 RESET = 1'b1;
        #1;
        check("arst_clk_en", {31'b0, CLK_MOUSE_OUT_EN}, 32'd0);
        check("arst_data_en", {31'b0, DATA_MOUSE_OUT_EN}, 32'd0);
        check("arst_busy", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        check("arst_sent", sent_cnt - s0, 32'd0);
        check("arst_err", err_cnt - e0, 32'd0);

`ifdef PS2_TX_RETRY_EN
        s0 = sent_cnt; e0 = err_cnt; i0 = inh_seen;
        send(8'h5A);
        dev_frame(1'b1, 11);
        dev_frame(1'b1, 11);
        dev_frame(1'b0, 11);
        wait_idle();
        check("retry_frame", {21'b0, cap}, 32'h6B4);
        check("retry_inhibits", inh_seen - i0, 32'd3);
        check("retry_sent", sent_cnt - s0, 32'd1);
        check("retry_err", err_cnt - e0, 32'd0);

        s0 = sent_cnt; e0 = err_cnt; i0 = inh_seen;
        send(8'h5A);
        dev_frame(1'b1, 11);
        dev_frame(1'b1, 11);
        dev_frame(1'b1, 11);
        wait_idle();
        check("exhaust_inhibits", inh_seen - i0, 32'd3);
        check("exhaust_err", err_cnt - e0, 32'd1);
        check("exhaust_sent", sent_cnt - s0, 32'd0);
        check("exhaust_code", {30'b0, ERR_CODE}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
